vdp_vram_arbiter: RTL and testbench
===================================

VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive screen grants allowed while a CPU request is pending.
REQ-002 Parameter TAG_DEPTH, default 4: maximum outstanding reads; power of two.
REQ-003 clk  in  1  system clock, 42.95454 MHz.
REQ-004 reset_n  in  1  reset; one clock, asynchronous, active-low.
REQ-005 scr_address  in  14  screen-fetch VRAM address.
REQ-006 scr_valid  in  1  screen read request; held until accepted.
REQ-007 scr_ready  out  1  screen request accepted at this edge.
REQ-008 scr_rdata / scr_rdata_en  out  8 / 1  screen read data and strobe.
REQ-009 cpu_address  in  14  CPU-port VRAM address.
REQ-010 cpu_valid / cpu_write  in  1 / 1  CPU request; 1 = write, 0 = read.
REQ-011 cpu_wdata  in  8  CPU write data.
REQ-012 cpu_ready  out  1  CPU request accepted at this edge.
REQ-013 cpu_rdata / cpu_rdata_en  out  8 / 1  CPU read data and strobe.
REQ-014 dram_address / dram_write / dram_wdata / dram_valid  out  14 / 1 / 8 / 1  VRAM request.
REQ-015 dram_ready  in  1  VRAM accepts the request at the edge where dram_valid=1 and dram_ready=1.
REQ-016 dram_rdata / dram_rdata_en  in  8 / 1  VRAM read return, in issue order, any latency >= 1.

Function
REQ-017 States: IDLE and BUSY; one request in flight on the dram request channel at a time.
REQ-018 IDLE: at an edge with an eligible request, latch address/write/wdata into dram_*, set dram_valid=1, pulse the winner's ready for exactly one cycle, go to BUSY.
REQ-019 Handshake: the requester treats valid=1 and ready=1 at an edge as accepted and may present a new request from the next cycle.
REQ-020 Priority: screen over CPU, except that a pending CPU request wins once the starve counter equals STARVE_LIMIT.
REQ-021 Starve counter: 3 bits; +1 on each screen grant while cpu_valid=1; saturates at STARVE_LIMIT; cleared on every CPU grant and whenever cpu_valid=0 in IDLE.
REQ-022 A read is eligible only when the tag FIFO is not full; a CPU write is always eligible.
REQ-023 If the tag FIFO is full, a blocked read does not block a pending CPU write.
REQ-024 BUSY: hold all dram_* outputs stable; at the edge with dram_ready=1, clear dram_valid, push a tag (0 = screen, 1 = CPU) if the request was a read, and return to IDLE.
REQ-025 Minimum spacing between two grants is 2 cycles; back-to-back requests with dram_ready tied high sustain one access per 2 clocks.
REQ-026 Read return: on dram_rdata_en=1, pop the tag; on the next edge, register dram_rdata into the tagged port's rdata and pulse that port's rdata_en for one cycle.
REQ-027 Push and pop at the same edge are both performed; occupancy is unchanged.
REQ-028 dram_rdata_en=1 with the FIFO empty is ignored: no strobe, no pointer change.
REQ-029 Tag FIFO pointers wrap modulo TAG_DEPTH, using an extra bit to distinguish full from empty.
REQ-030 Neither rdata output changes except on its own strobe.
REQ-031 The CPU write path never produces an rdata strobe.

Reset
REQ-032 When reset_n=0, immediately: state IDLE; dram_valid, dram_write, scr_ready, cpu_ready, scr_rdata_en and cpu_rdata_en = 0; dram_address, dram_wdata, scr_rdata and cpu_rdata = 0; FIFO empty; starve counter 0.
REQ-033 Reset in BUSY abandons the request; read data returned after reset release for pre-reset reads is discarded per REQ-028.
REQ-034 The first grant is possible at the first edge after reset_n rises.

Verification
REQ-035 CPU write only: cpu_valid=1, write=1, addr 0x1234, wdata 0x5A, dram_ready=1 -> cpu_ready one cycle later, dram_valid one cycle with 0x1234/0x5A/write=1; no rdata strobe.
REQ-036 Simultaneous reads: scr addr 0x0100 and cpu addr 0x0200 -> screen granted first, CPU granted 2 cycles later; RAM returns 0x11 then 0x22 -> scr_rdata=0x11 and cpu_rdata=0x22, each with a one-cycle strobe.
REQ-037 Starvation: continuous scr_valid plus cpu_valid -> exactly 4 screen grants, then 1 CPU grant; the pattern repeats.
REQ-038 FIFO full: dram_rdata_en held 0, 4 screen reads issued -> 5th read not granted while a CPU write is granted; one return -> 5th read granted.
REQ-039 Reset mid-BUSY: reset_n low for 2 cycles with dram_ready=0 -> dram_valid=0 immediately; a late dram_rdata_en produces no output strobe.
REQ-040 Stall: dram_ready low for 10 cycles -> dram_* outputs constant throughout; completion on the first edge with dram_ready high.

Source files
------------

// File: rtl/vdp_vram_arbiter.sv
// VRAM arbiter: merges screen-fetch and CPU accesses onto one request channel
// and steers in-order read returns back to their owner through a tag FIFO.
module vdp_vram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TAG_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] scr_address,
    input  logic        scr_valid,
    output logic        scr_ready,
    output logic [7:0]  scr_rdata,
    output logic        scr_rdata_en,
    input  logic [13:0] cpu_address,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    output logic [13:0] dram_address,
    output logic        dram_write,
    output logic [7:0]  dram_wdata,
    output logic        dram_valid,
    input  logic        dram_ready,
    input  logic [7:0]  dram_rdata,
    input  logic        dram_rdata_en
);

    localparam int unsigned PW      = $clog2(TAG_DEPTH);
    localparam logic [2:0]  LIMIT   = 3'(STARVE_LIMIT);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state_q, state_d;
    logic [13:0]    dram_address_q, dram_address_d;
    logic           dram_write_q, dram_write_d;
    logic [7:0]     dram_wdata_q, dram_wdata_d;
    logic           dram_valid_q, dram_valid_d;
    logic           req_tag_q, req_tag_d;
    logic           scr_ready_q, scr_ready_d;
    logic           cpu_ready_q, cpu_ready_d;
    logic [2:0]     starve_q, starve_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PW:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]     scr_rdata_q, scr_rdata_d;
    logic           scr_rdata_en_q, scr_rdata_en_d;
    logic [7:0]     cpu_rdata_q, cpu_rdata_d;
    logic           cpu_rdata_en_q, cpu_rdata_en_d;

    logic fifo_empty;
    logic fifo_full;
    logic scr_elig;
    logic cpu_elig;
    logic cpu_wins;
    logic scr_wins;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // Reads need a free tag slot; CPU writes never wait on the FIFO.
    assign scr_elig = scr_valid && !fifo_full;
    assign cpu_elig = cpu_valid && (cpu_write || !fifo_full);
    assign cpu_wins = cpu_elig && (!scr_elig || (starve_q == LIMIT));
    assign scr_wins = scr_elig && !cpu_wins;

    always_comb begin
        state_d        = state_q;
        dram_address_d = dram_address_q;
        dram_write_d   = dram_write_q;
        dram_wdata_d   = dram_wdata_q;
        dram_valid_d   = dram_valid_q;
        req_tag_d      = req_tag_q;
        scr_ready_d    = 1'b0;
        cpu_ready_d    = 1'b0;
        starve_d       = starve_q;
        tag_d          = tag_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        scr_rdata_d    = scr_rdata_q;
        scr_rdata_en_d = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_rdata_en_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cpu_valid) begin
                    starve_d = '0;
                end
                if (cpu_wins) begin
                    dram_address_d = cpu_address;
                    dram_write_d   = cpu_write;
                    dram_wdata_d   = cpu_wdata;
                    dram_valid_d   = 1'b1;
                    req_tag_d      = 1'b1;
                    cpu_ready_d    = 1'b1;
                    starve_d       = '0;
                    state_d        = BUSY;
                end else if (scr_wins) begin
                    dram_address_d = scr_address;
                    dram_write_d   = 1'b0;
                    dram_valid_d   = 1'b1;
                    req_tag_d      = 1'b0;
                    scr_ready_d    = 1'b1;
                    if (cpu_valid && (starve_q != LIMIT)) begin
                        starve_d = starve_q + 3'd1;
                    end
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (dram_ready) begin
                    dram_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (!dram_write_q) begin
                        tag_d[wr_ptr_q[PW-1:0]] = req_tag_q;
                        wr_ptr_d                = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Returns with no outstanding tag (e.g. pre-reset reads) are dropped.
        if (dram_rdata_en && !fifo_empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (tag_q[rd_ptr_q[PW-1:0]]) begin
                cpu_rdata_d    = dram_rdata;
                cpu_rdata_en_d = 1'b1;
            end else begin
                scr_rdata_d    = dram_rdata;
                scr_rdata_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            dram_address_q <= '0;
            dram_write_q   <= 1'b0;
            dram_wdata_q   <= '0;
            dram_valid_q   <= 1'b0;
            req_tag_q      <= 1'b0;
            scr_ready_q    <= 1'b0;
            cpu_ready_q    <= 1'b0;
            starve_q       <= '0;
            tag_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            scr_rdata_q    <= '0;
            scr_rdata_en_q <= 1'b0;
            cpu_rdata_q    <= '0;
            cpu_rdata_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dram_address_q <= dram_address_d;
            dram_write_q   <= dram_write_d;
            dram_wdata_q   <= dram_wdata_d;
            dram_valid_q   <= dram_valid_d;
            req_tag_q      <= req_tag_d;
            scr_ready_q    <= scr_ready_d;
            cpu_ready_q    <= cpu_ready_d;
            starve_q       <= starve_d;
            tag_q          <= tag_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            scr_rdata_q    <= scr_rdata_d;
            scr_rdata_en_q <= scr_rdata_en_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_rdata_en_q <= cpu_rdata_en_d;
        end
    end

    assign dram_address = dram_address_q;
    assign dram_write   = dram_write_q;
    assign dram_wdata   = dram_wdata_q;
    assign dram_valid   = dram_valid_q;
    assign scr_ready    = scr_ready_q;
    assign cpu_ready    = cpu_ready_q;
    assign scr_rdata    = scr_rdata_q;
    assign scr_rdata_en = scr_rdata_en_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rdata_en = cpu_rdata_en_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed testbench for vdp_vram_arbiter with hand-computed expectations.
`timescale 1ns/1ps
module tb_vdp_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [13:0] scr_address = '0;
    logic        scr_valid = 1'b0;
    logic        scr_ready;
    logic [7:0]  scr_rdata;
    logic        scr_rdata_en;
    logic [13:0] cpu_address = '0;
    logic        cpu_valid = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_en;
    logic [13:0] dram_address;
    logic        dram_write;
    logic [7:0]  dram_wdata;
    logic        dram_valid;
    logic        dram_ready = 1'b0;
    logic [7:0]  dram_rdata = '0;
    logic        dram_rdata_en = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    vdp_vram_arbiter #(
        .STARVE_LIMIT (4),
        .TAG_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .scr_address   (scr_address),
        .scr_valid     (scr_valid),
        .scr_ready     (scr_ready),
        .scr_rdata     (scr_rdata),
        .scr_rdata_en  (scr_rdata_en),
        .cpu_address   (cpu_address),
        .cpu_valid     (cpu_valid),
        .cpu_write     (cpu_write),
        .cpu_wdata     (cpu_wdata),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .cpu_rdata_en  (cpu_rdata_en),
        .dram_address  (dram_address),
        .dram_write    (dram_write),
        .dram_wdata    (dram_wdata),
        .dram_valid    (dram_valid),
        .dram_ready    (dram_ready),
        .dram_rdata    (dram_rdata),
        .dram_rdata_en (dram_rdata_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({scr_ready, cpu_ready, dram_valid, dram_write, scr_rdata_en, cpu_rdata_en} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=000000",
                     {scr_ready, cpu_ready, dram_valid, dram_write, scr_rdata_en, cpu_rdata_en});
        end
        tick();
        tick();
        vectors++;
        if ({dram_address, dram_wdata, scr_rdata, cpu_rdata} !== 38'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h want=0",
                     {dram_address, dram_wdata, scr_rdata, cpu_rdata});
        end
        cpu_valid   = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 14'h0003;
        cpu_wdata   = 8'h01;
        dram_ready  = 1'b1;
        reset_n     = 1'b1;
        tick();
        vectors++;
        if ({cpu_ready, dram_valid, dram_address} !== {1'b1, 1'b1, 14'h0003}) begin
            miscompares++;
            $display("FAIL first_grant got=%b/%b/%h want=1/1/0003", cpu_ready, dram_valid, dram_address);
        end
        tick();
        cpu_valid = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        cpu_valid   = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 14'h1234;
        cpu_wdata   = 8'h5A;
        dram_ready  = 1'b1;
        tick();
        vectors++;
        if ({cpu_ready, scr_ready, dram_valid, dram_write, dram_address, dram_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 14'h1234, 8'h5A}) begin
            miscompares++;
            $display("FAIL cpuwr_grant got rdy=%b srdy=%b v=%b w=%b a=%h d=%h want 1 0 1 1 1234 5a",
                     cpu_ready, scr_ready, dram_valid, dram_write, dram_address, dram_wdata);
        end
        tick();
        vectors++;
        if ({cpu_ready, dram_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL cpuwr_done got rdy=%b v=%b want 0 0", cpu_ready, dram_valid);
        end
        cpu_valid = 1'b0;
        cpu_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({scr_rdata_en, cpu_rdata_en, dram_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL cpuwr_nostrobe got=%b want=000", {scr_rdata_en, cpu_rdata_en, dram_valid});
            end
        end
    endtask

    task automatic test_simul_reads();
        scr_valid   = 1'b1;
        scr_address = 14'h0100;
        cpu_valid   = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 14'h0200;
        dram_ready  = 1'b1;
        tick();
        vectors++;
        if ({scr_ready, cpu_ready, dram_valid, dram_write, dram_address} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 14'h0100}) begin
            miscompares++;
            $display("FAIL rd_scr_grant got s=%b c=%b v=%b w=%b a=%h want 1 0 1 0 0100",
                     scr_ready, cpu_ready, dram_valid, dram_write, dram_address);
        end
        tick();
        vectors++;
        if ({scr_ready, cpu_ready, dram_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rd_spacing got=%b want=000", {scr_ready, cpu_ready, dram_valid});
        end
        scr_valid = 1'b0;
        tick();
        vectors++;
        if ({scr_ready, cpu_ready, dram_valid, dram_address} !== {1'b0, 1'b1, 1'b1, 14'h0200}) begin
            miscompares++;
            $display("FAIL rd_cpu_grant got s=%b c=%b v=%b a=%h want 0 1 1 0200",
                     scr_ready, cpu_ready, dram_valid, dram_address);
        end
        tick();
        cpu_valid     = 1'b0;
        dram_rdata    = 8'h11;
        dram_rdata_en = 1'b1;
        tick();
        vectors++;
        if ({scr_rdata_en, scr_rdata, cpu_rdata_en} !== {1'b1, 8'h11, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_scr_return got en=%b d=%h cen=%b want 1 11 0", scr_rdata_en, scr_rdata, cpu_rdata_en);
        end
        dram_rdata = 8'h22;
        tick();
        vectors++;
        if ({cpu_rdata_en, cpu_rdata, scr_rdata_en, scr_rdata} !== {1'b1, 8'h22, 1'b0, 8'h11}) begin
            miscompares++;
            $display("FAIL rd_cpu_return got cen=%b cd=%h sen=%b sd=%h want 1 22 0 11",
                     cpu_rdata_en, cpu_rdata, scr_rdata_en, scr_rdata);
        end
        dram_rdata_en = 1'b0;
        tick();
        vectors++;
        if ({cpu_rdata_en, cpu_rdata, scr_rdata_en} !== {1'b0, 8'h22, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_strobe_width got cen=%b cd=%h sen=%b want 0 22 0", cpu_rdata_en, cpu_rdata, scr_rdata_en);
        end
    endtask

    task automatic test_starve();
        logic [9:0] pat;
        int unsigned n;
        pat = 10'b10_0001_0000;
        n = 0;
        scr_valid     = 1'b1;
        scr_address   = 14'h0300;
        cpu_valid     = 1'b1;
        cpu_write     = 1'b1;
        cpu_address   = 14'h0301;
        cpu_wdata     = 8'hEE;
        dram_ready    = 1'b1;
        dram_rdata_en = 1'b1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick();
            if (scr_ready || cpu_ready) begin
                vectors++;
                if ({scr_ready, cpu_ready} !== {~pat[n], pat[n]}) begin
                    miscompares++;
                    $display("FAIL starve_grant%0d got s=%b c=%b want s=%b c=%b",
                             n, scr_ready, cpu_ready, ~pat[n], pat[n]);
                end
                n++;
            end
        end
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL starve_timeout got %0d grants want 10", n);
        end
        scr_valid = 1'b0;
        cpu_valid = 1'b0;
        cpu_write = 1'b0;
        repeat (3) tick();
        dram_rdata_en = 1'b0;
        tick();
    endtask

    task automatic test_fifo_full();
        int unsigned n;
        n = 0;
        scr_valid   = 1'b1;
        scr_address = 14'h0050;
        dram_ready  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (scr_ready) n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL full_scr_grants got %0d want 4", n);
        end
        cpu_valid   = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 14'h0042;
        cpu_wdata   = 8'hA5;
        tick();
        vectors++;
        if ({cpu_ready, scr_ready, dram_write, dram_address, dram_wdata} !==
            {1'b1, 1'b0, 1'b1, 14'h0042, 8'hA5}) begin
            miscompares++;
            $display("FAIL full_cpu_write got c=%b s=%b w=%b a=%h d=%h want 1 0 1 0042 a5",
                     cpu_ready, scr_ready, dram_write, dram_address, dram_wdata);
        end
        tick();
        cpu_valid = 1'b0;
        cpu_write = 1'b0;
        tick();
        vectors++;
        if (scr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_blocked got s=%b want 0", scr_ready);
        end
        dram_rdata    = 8'h77;
        dram_rdata_en = 1'b1;
        tick();
        vectors++;
        if ({scr_rdata_en, scr_rdata, scr_ready} !== {1'b1, 8'h77, 1'b0}) begin
            miscompares++;
            $display("FAIL full_pop got en=%b d=%h s=%b want 1 77 0", scr_rdata_en, scr_rdata, scr_ready);
        end
        dram_rdata_en = 1'b0;
        tick();
        vectors++;
        if ({scr_ready, dram_address} !== {1'b1, 14'h0050}) begin
            miscompares++;
            $display("FAIL full_fifth_grant got s=%b a=%h want 1 0050", scr_ready, dram_address);
        end
        tick();
        scr_valid = 1'b0;
        n = 0;
        dram_rdata_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (scr_rdata_en) n++;
        end
        dram_rdata_en = 1'b0;
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL full_drain got %0d strobes want 4", n);
        end
    endtask

    task automatic test_stall();
        cpu_valid   = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 14'h2BCD;
        cpu_wdata   = 8'hC3;
        dram_ready  = 1'b0;
        tick();
        vectors++;
        if ({cpu_ready, dram_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL stall_grant got c=%b v=%b want 1 1", cpu_ready, dram_valid);
        end
        tick();
        cpu_valid   = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = 14'h0000;
        cpu_wdata   = 8'hFF;
        scr_valid   = 1'b1;
        scr_address = 14'h0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if ({dram_valid, dram_write, dram_address, dram_wdata, scr_ready} !==
                {1'b1, 1'b1, 14'h2BCD, 8'hC3, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d got v=%b w=%b a=%h d=%h s=%b want 1 1 2bcd c3 0",
                         c, dram_valid, dram_write, dram_address, dram_wdata, scr_ready);
            end
        end
        dram_ready = 1'b1;
        tick();
        vectors++;
        if ({dram_valid, scr_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_complete got v=%b s=%b want 0 0", dram_valid, scr_ready);
        end
        tick();
        vectors++;
        if ({scr_ready, dram_write, dram_address} !== {1'b1, 1'b0, 14'h0001}) begin
            miscompares++;
            $display("FAIL stall_next_grant got s=%b w=%b a=%h want 1 0 0001", scr_ready, dram_write, dram_address);
        end
        tick();
        scr_valid     = 1'b0;
        dram_rdata    = 8'h3C;
        dram_rdata_en = 1'b1;
        tick();
        dram_rdata_en = 1'b0;
        vectors++;
        if ({scr_rdata_en, scr_rdata} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL stall_return got en=%b d=%h want 1 3c", scr_rdata_en, scr_rdata);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        scr_valid   = 1'b1;
        scr_address = 14'h0ABC;
        dram_ready  = 1'b0;
        tick();
        tick();
        vectors++;
        if ({dram_valid, dram_address} !== {1'b1, 14'h0ABC}) begin
            miscompares++;
            $display("FAIL rstbusy_inflight got v=%b a=%h want 1 0abc", dram_valid, dram_address);
        end
        scr_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        vectors++;
        if ({dram_valid, dram_address, scr_rdata} !== {1'b0, 14'h0000, 8'h00}) begin
            miscompares++;
            $display("FAIL rstbusy_async got v=%b a=%h sd=%h want 0 0000 00", dram_valid, dram_address, scr_rdata);
        end
        tick();
        tick();
        reset_n       = 1'b1;
        dram_rdata    = 8'h99;
        dram_rdata_en = 1'b1;
        tick();
        dram_rdata_en = 1'b0;
        vectors++;
        if ({scr_rdata_en, cpu_rdata_en, scr_rdata, cpu_rdata, dram_valid} !== 19'h0) begin
            miscompares++;
            $display("FAIL rstbusy_late_return got sen=%b cen=%b sd=%h cd=%h v=%b want all 0",
                     scr_rdata_en, cpu_rdata_en, scr_rdata, cpu_rdata, dram_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_simul_reads();
        test_starve();
        test_fifo_full();
        test_stall();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
